stc_psum_drain: RTL

Output drain stage sitting directly downstream of the STC accumulator. It snapshots the accumulator's full partial-sum tile (N_PE rows of N lanes) when the controller signals tile completion. It then streams the tile out one PE row per beat on a valid/ready interface toward the result write-back path. This frees the accumulator to start the next tile immediately.

---
 rtl/stc_pkg.sv | 26 ++
 rtl/stc_relu_vec.sv | 25 ++
 rtl/stc_psum_drain.sv | 133 +++++++++++++
 3 files changed

// File: rtl/stc_pkg.sv
// ============================================================================
// Module   : stc_pkg
// Purpose  : Shared constants, drain FSM state type and row-index width helper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package stc_pkg;

  localparam int c_DW_DATA = 32;
  localparam int c_N       = 16;
  localparam int c_N_PE    = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_state_e;

  // A single-row tile still needs a 1-bit index port.
  function automatic int stc_row_w(input int n_rows);
    return (n_rows > 1) ? $clog2(n_rows) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/stc_relu_vec.sv
// ============================================================================
// Module   : stc_relu_vec
// Purpose  : Combinational N-lane clamp; negative two's-complement lanes -> 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stc_relu_vec
  import stc_pkg::*;
#(
  parameter int N       = c_N,
  parameter int DW_DATA = c_DW_DATA
) (
  input  logic [N*DW_DATA-1:0] i_vec,
  output logic [N*DW_DATA-1:0] o_vec
);

  for (genvar l = 0; l < N; l++) begin : g_lane
    assign o_vec[l*DW_DATA +: DW_DATA] =
      i_vec[l*DW_DATA + DW_DATA - 1] ? '0 : i_vec[l*DW_DATA +: DW_DATA];
  end

endmodule

`default_nettype wire

// File: rtl/stc_psum_drain.sv
// ============================================================================
// Module   : stc_psum_drain
// Purpose  : Snapshots an accumulator tile on capture and streams it out one
//            PE row per valid/ready beat. Optional clamp: STC_DRAIN_RELU_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stc_psum_drain
  import stc_pkg::*;
#(
  parameter int N_PE    = c_N_PE,
  parameter int N       = c_N,
  parameter int DW_DATA = c_DW_DATA
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_PE*N*DW_DATA-1:0]     in_psum,
  input  logic                          capture,
  output logic                          busy,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [N*DW_DATA-1:0]          out_data,
  output logic [stc_row_w(N_PE)-1:0]    out_row,
  output logic                          out_last,
  output logic [15:0]                   tile_cnt,
  output logic                          err_drop
);

  localparam int                 c_ROW_W    = N * DW_DATA;
  localparam int                 c_IDX_W    = stc_row_w(N_PE);
  localparam logic [c_IDX_W-1:0] c_LAST_ROW = c_IDX_W'(N_PE - 1);

  drain_state_e         r_state;
  drain_state_e         w_state_nxt;
  logic [c_IDX_W-1:0]   r_row;
  logic [c_ROW_W-1:0]   r_buf [N_PE];
  logic [15:0]          r_tile_cnt;
  logic                 r_err_drop;

  logic [N_PE*c_ROW_W-1:0] w_tile;
  logic                    w_accept;
  logic                    w_done;
  logic                    w_load;
  logic                    w_drop;

`ifdef STC_DRAIN_RELU_EN
  for (genvar r = 0; r < N_PE; r++) begin : g_relu_row
    stc_relu_vec #(
      .N       (N),
      .DW_DATA (DW_DATA)
    ) u_relu (
      .i_vec (in_psum[r*c_ROW_W +: c_ROW_W]),
      .o_vec (w_tile[r*c_ROW_W +: c_ROW_W])
    );
  end
`else
  assign w_tile = in_psum;
`endif

  assign w_accept = (r_state == DRAIN) && out_ready;
  assign w_done   = w_accept && (r_row == c_LAST_ROW);
  // A capture coinciding with the final accept chains the next tile with no bubble.
  assign w_load   = capture && ((r_state == IDLE) || w_done);
  assign w_drop   = capture && (r_state == DRAIN) && !w_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (capture) w_state_nxt = DRAIN;
      DRAIN:   if (w_done && !capture) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_row   = '0;
    out_last  = 1'b0;
    if (r_state == DRAIN) begin
      busy      = 1'b1;
      out_valid = 1'b1;
      out_data  = r_buf[r_row];
      out_row   = r_row;
      out_last  = (r_row == c_LAST_ROW);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_row      <= '0;
      r_tile_cnt <= '0;
      r_err_drop <= 1'b0;
    end else begin
      if (w_load || w_done) begin
        r_row <= '0;
      end else if (w_accept) begin
        r_row <= r_row + 1'b1;
      end
      if (w_done) begin
        r_tile_cnt <= r_tile_cnt + 16'd1;
      end
      if (w_drop) begin
        r_err_drop <= 1'b1;
      end
    end
  end

  // Payload storage carries no reset; outputs are gated by state instead.
  always_ff @(posedge clk) begin
    if (!reset && w_load) begin
      for (int r = 0; r < N_PE; r++) begin
        r_buf[r] <= w_tile[r*c_ROW_W +: c_ROW_W];
      end
    end
  end

  assign tile_cnt = r_tile_cnt;
  assign err_drop = r_err_drop;

endmodule

`default_nettype wire
